// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and slice selects for the serial ALU
package alu_pkg;
   localparam int CPU_WIDTH = 24;
   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101
   } op_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
   typedef enum logic [2:0] {SEL_AND, SEL_OR, SEL_SUM, SEL_XOR, SEL_LESS} sel_e;
   // Reserved ops select the Less input, which is tied low, so they shift in zeros.
   function automatic sel_e op_sel(logic [2:0] op);
      return op == OP_AND ? SEL_AND :
             op == OP_OR  ? SEL_OR  :
             op == OP_XOR ? SEL_XOR :
             (op == OP_ADD || op == OP_SUB || op == OP_SLT) ? SEL_SUM : SEL_LESS;
   endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// alu_bit_slice: combinational 1-bit ALU slice with B inversion and carry chain
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   input  logic binv_i,
   input  logic less_i,
   input  sel_e sel_i,
   output logic result_o,
   output logic cout_o
);
   logic bb;
   // Full-adder carry plus the selected bitwise/sum result
   always_comb begin
      bb = b_i ^ binv_i;
      cout_o = (a_i & bb) | (a_i & cin_i) | (bb & cin_i);
      result_o = sel_i == SEL_AND ? a_i & bb :
                 sel_i == SEL_OR  ? a_i | bb :
                 sel_i == SEL_SUM ? a_i ^ bb ^ cin_i :
                 sel_i == SEL_XOR ? a_i ^ bb : less_i;
   end
endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial execute stage; ALU_SERIAL_FLAGS_EN enables carry/zero/ovf outputs
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = CPU_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_ovf
);
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_sh_q, b_sh_q;
   logic [WIDTH-1:1] res_sh_q;
   logic [2:0]       op_q;
`ifdef ALU_SERIAL_FLAGS_EN
   logic             zacc_q;
`endif
   logic             bit_res, bit_cout;
   logic             last, arith, is_sub, ovf_i, slt_bit;
   logic [WIDTH-1:0] res_shift, res_d;
   logic             carry_d, zero_d, ovf_d;

   alu_bit_slice u_slice (
      .a_i      (a_sh_q[0]),
      .b_i      (b_sh_q[0]),
      .cin_i    (carry_q),
      .binv_i   (is_sub),
      .less_i   (1'b0),
      .sel_i    (op_sel(op_q)),
      .result_o (bit_res),
      .cout_o   (bit_cout)
   );

   assign in_ready  = state_q == S_IDLE;
   assign out_valid = state_q == S_DONE;

   // Final-bit result assembly and flag terms, valid on the MSB cycle
   always_comb begin
      last = cnt_q == CNT_W'(WIDTH - 1);
      is_sub = op_q == OP_SUB || op_q == OP_SLT;
      arith = is_sub || op_q == OP_ADD;
      ovf_i = carry_q ^ bit_cout;
      slt_bit = bit_res ^ ovf_i;
      res_shift = {bit_res, res_sh_q};
      res_d = op_q == OP_SLT ? {{(WIDTH-1){1'b0}}, slt_bit} : res_shift;
`ifdef ALU_SERIAL_FLAGS_EN
      carry_d = arith & bit_cout;
      ovf_d = arith & ovf_i;
      zero_d = op_q == OP_SLT ? ~slt_bit : (arith || op_q == OP_AND || op_q == OP_OR || op_q == OP_XOR) & ~(zacc_q | bit_res);
`else
      carry_d = 1'b0;
      ovf_d = 1'b0;
      zero_d = 1'b0;
`endif
   end

   // Sequencer: accept, shift WIDTH bits through the slice, hold result until taken
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         carry_q <= 1'b0;
         a_sh_q <= '0;
         b_sh_q <= '0;
         res_sh_q <= '0;
         op_q <= '0;
         out_result <= '0;
         out_carry <= 1'b0;
         out_zero <= 1'b0;
         out_ovf <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
         zacc_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               a_sh_q <= in_a;
               b_sh_q <= in_b;
               op_q <= in_op;
               cnt_q <= '0;
               carry_q <= in_op == OP_SUB || in_op == OP_SLT;
`ifdef ALU_SERIAL_FLAGS_EN
               zacc_q <= 1'b0;
`endif
               state_q <= S_RUN;
            end
            S_RUN: begin
               a_sh_q <= a_sh_q >> 1;
               b_sh_q <= b_sh_q >> 1;
               res_sh_q <= res_shift[WIDTH-1:1];
               carry_q <= bit_cout;
`ifdef ALU_SERIAL_FLAGS_EN
               zacc_q <= zacc_q | bit_res;
`endif
               if (last) begin
                  out_result <= res_d;
                  out_carry <= carry_d;
                  out_zero <= zero_d;
                  out_ovf <= ovf_d;
                  state_q <= S_DONE;
               end else
                  cnt_q <= cnt_q + CNT_W'(1);
            end
            S_DONE: if (out_ready) state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: directed and random transactions against an arithmetic reference model
module tb_alu_serial_seq;
   import alu_pkg::*;
   localparam int W = CPU_WIDTH;

   logic         clk = 1'b0, rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] in_a, in_b, out_result;
   logic [2:0]   in_op;
   logic         out_carry, out_zero, out_ovf;
   int           cyc = 0, n_chk = 0, n_fail = 0;

   alu_serial_seq dut (
      .Clock(clk), .Reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_result(out_result), .out_carry(out_carry),
      .out_zero(out_zero), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic c, output logic z, output logic v);
      logic [W:0] s;
      r = '0; c = 1'b0; z = 1'b0; v = 1'b0;
      case (op)
         3'b000: r = a & b;
         3'b001: r = a | b;
         3'b100: r = a ^ b;
         3'b010: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'b011, 3'b101: begin
            s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            r = s[W-1:0]; c = s[W];
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            if (op == 3'b101) r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         end
         default: ;
      endcase
      z = (op <= 3'b101) && (r == '0);
`ifndef ALU_SERIAL_FLAGS_EN
      c = 1'b0; z = 1'b0; v = 1'b0;
`endif
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
      logic [W-1:0] er;
      logic ec, ez, ev;
      int t, k;
      model(op, a, b, er, ec, ez, ev);
      @(negedge clk);
      check("idle_ready", in_ready, 1);
      in_valid = 1; in_a = a; in_b = b; in_op = op; out_ready = (stall == 0); t = cyc;
      @(negedge clk);
      in_valid = 0;
      check("busy_ready", in_ready, 0);
      k = 0;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("latency", cyc - t, W + 1);
      check("result", out_result, er);
      check("carry", out_carry, ec);
      check("zero", out_zero, ez);
      check("ovf", out_ovf, ev);
      for (int i = 0; i < stall; i++) begin
         in_valid = 1; in_a = W'($urandom); in_b = W'($urandom); in_op = 3'($urandom_range(0, 7));
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_result", out_result, er);
         check("hold_flags", {out_carry, out_zero, out_ovf}, {ec, ez, ev});
         check("hold_ready", in_ready, 0);
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      check("released_valid", out_valid, 0);
      check("ready_after", in_ready, 1);
   endtask

   initial begin
      logic [2:0] ops [10] = '{3'b010, 3'b011, 3'b010, 3'b101, 3'b101, 3'b000, 3'b001, 3'b100, 3'b010, 3'b110};
      logic [W-1:0] as [10] = '{24'h000005, 24'h000000, 24'h7FFFFF, 24'hFFFFFF, 24'h000001,
                                24'hF0F0F0, 24'hF0F0F0, 24'hF0F0F0, 24'hFFFFFF, 24'h123456};
      logic [W-1:0] bs [10] = '{24'h000003, 24'h000001, 24'h000001, 24'h000001, 24'hFFFFFF,
                                24'hFF00FF, 24'hFF00FF, 24'hFF00FF, 24'h000001, 24'h654321};
      int cnt_v;
      rst = 1; in_valid = 0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_result", out_result, 0);
      check("rst_flags", {out_carry, out_zero, out_ovf}, 0);
      rst = 0;
      for (int i = 0; i < 10; i++) run_op(ops[i], as[i], bs[i], 0);
      run_op(3'b011, 24'h000010, 24'h000020, 10);
      @(negedge clk);
      in_valid = 1; in_op = 3'b011; in_a = 24'hABCDEF; in_b = 24'h000001; out_ready = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (12) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      check("midrst_ready", in_ready, 1);
      check("midrst_valid", out_valid, 0);
      check("midrst_result", out_result, 0);
      check("midrst_flags", {out_carry, out_zero, out_ovf}, 0);
      cnt_v = 0;
      repeat (30) begin
         @(negedge clk);
         cnt_v += int'(out_valid);
      end
      check("midrst_no_output", cnt_v, 0);
      run_op(3'b010, 24'h000001, 24'h000001, 0);
      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? W'(24'h7FFFFF + $urandom_range(0, 2)) : W'($urandom),
                ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 1)) : W'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
